// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state encodings and sizing constants for the snake game controller.
package snake_pkg;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FOOD, ST_RUN, ST_OVER} state_t;
  localparam int INIT_LEN = 3;
  localparam int PER_W = 24;
  function automatic dir_t dir_rev(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: move-period counter; the period shrinks with length only when SNAKE_SPEEDUP_EN is defined.
module snake_tick_gen
  import snake_pkg::*;
#(
  parameter int TICK_BASE = 2500000,
  parameter int TICK_STEP = 50000,
  parameter int TICK_MIN  = 750000
) (
  input  logic       Clock,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] length,
  output logic       tick
);
  logic [PER_W-1:0] r_count;
  logic [PER_W-1:0] w_period;
`ifdef SNAKE_SPEEDUP_EN
  logic [PER_W-1:0] w_dec;
  assign w_dec = PER_W'(TICK_STEP) * PER_W'(length - 8'(INIT_LEN));
  // clamp is decided before subtracting so the period never wraps
  assign w_period = (w_dec >= PER_W'(TICK_BASE - TICK_MIN)) ? PER_W'(TICK_MIN) : PER_W'(TICK_BASE) - w_dec;
`else
  localparam int unused_tick_cfg = TICK_STEP + TICK_MIN;
  logic w_unused_len;
  assign w_unused_len = ^length;
  assign w_period = PER_W'(TICK_BASE);
`endif
  assign tick = enable && !clear && (r_count >= w_period - PER_W'(1));
  always_ff @(posedge Clock)
    if (clear || tick) r_count <= '0;
    else if (enable) r_count <= r_count + PER_W'(1);
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake game FSM (idle/food/run/over), direction latching and growth.
// Define SNAKE_SPEEDUP_EN to make the move period shrink as the snake grows.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_BASE = 2500000,
  parameter int TICK_STEP = 50000,
  parameter int TICK_MIN  = 750000,
  parameter int MAX_LEN   = 200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iNorth,
  input  logic       iSouth,
  input  logic       iEast,
  input  logic       iWest,
  input  logic       iEat,
  input  logic       iCollide,
  input  logic       iFoodAck,
  output logic [1:0] oDir,
  output logic       oMoveTick,
  output logic       oFoodReq,
  output logic [7:0] oSnakeLength,
  output logic       oGameOver,
  output logic       oWin,
  output logic [1:0] oState
);
  state_t     r_state, w_state_nxt;
  dir_t       r_dir, r_pend, w_req;
  logic [7:0] r_len, w_len_inc;
  logic       r_tick, r_food_req, r_over, r_win;
  logic       w_any, w_tick, w_enable, w_clear;
  assign w_any = iNorth | iSouth | iEast | iWest;
  assign w_req = iNorth ? DIR_N : iSouth ? DIR_S : iEast ? DIR_E : DIR_W;
  assign w_len_inc = (r_len >= 8'(MAX_LEN)) ? r_len : r_len + 8'd1;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_any ? ST_FOOD : ST_IDLE;
      ST_FOOD: w_state_nxt = iFoodAck ? ST_RUN : ST_FOOD;
      ST_RUN:  w_state_nxt = iCollide ? ST_OVER : !iEat ? ST_RUN : (w_len_inc == 8'(MAX_LEN)) ? ST_OVER : ST_FOOD;
      default: w_state_nxt = ST_OVER;
    endcase
  end
  // counting stops on the leaving edge so no tick lands in FOOD or OVER
  assign w_enable = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_clear = !Reset || (r_state == ST_IDLE) || (r_state == ST_OVER);
  snake_tick_gen #(
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP),
    .TICK_MIN (TICK_MIN)
  ) u_tick (
    .Clock (Clock),
    .enable(w_enable),
    .clear (w_clear),
    .length(r_len),
    .tick  (w_tick)
  );
  always_ff @(posedge Clock)
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_E;
      r_pend     <= DIR_E;
      r_len      <= 8'(INIT_LEN);
      r_tick     <= 1'b0;
      r_food_req <= 1'b0;
      r_over     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick;
      r_food_req <= w_state_nxt == ST_FOOD;
      r_over     <= w_state_nxt == ST_OVER;
      if (r_state == ST_RUN && w_any && w_req != dir_rev(r_dir)) r_pend <= w_req;
      if (w_tick) r_dir <= r_pend;
      if (r_state == ST_RUN && iEat && !iCollide) begin
        r_len <= w_len_inc;
        r_win <= w_len_inc == 8'(MAX_LEN);
      end
    end
  assign oDir = r_dir;
  assign oMoveTick = r_tick;
  assign oFoodReq = r_food_req;
  assign oSnakeLength = r_len;
  assign oGameOver = r_over;
  assign oWin = r_win;
  assign oState = r_state;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed table, corner sequences and a random run against a cycle model.
module tb_snake_game_ctrl;
  localparam int TB = 20, TS = 2, TM = 8, MAXL = 200;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_n = 0, btn_s = 0, btn_e = 0, btn_w = 0, eat = 0, col = 0, ack = 0;
  logic [1:0] dir, st, dir_w, st_w;
  logic [7:0] len, len_w;
  logic tick, req, over, win, tick_w, req_w, over_w, win_w;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  snake_game_ctrl #(.TICK_BASE(TB), .TICK_STEP(TS), .TICK_MIN(TM), .MAX_LEN(MAXL)) dut (
    .Clock(clk), .Reset(rst_n), .iNorth(btn_n), .iSouth(btn_s), .iEast(btn_e), .iWest(btn_w),
    .iEat(eat), .iCollide(col), .iFoodAck(ack), .oDir(dir), .oMoveTick(tick), .oFoodReq(req),
    .oSnakeLength(len), .oGameOver(over), .oWin(win), .oState(st));
  snake_game_ctrl #(.TICK_BASE(TB), .TICK_STEP(TS), .TICK_MIN(TM), .MAX_LEN(5)) dut_w (
    .Clock(clk), .Reset(rst_n), .iNorth(btn_n), .iSouth(btn_s), .iEast(btn_e), .iWest(btn_w),
    .iEat(eat), .iCollide(col), .iFoodAck(ack), .oDir(dir_w), .oMoveTick(tick_w), .oFoodReq(req_w),
    .oSnakeLength(len_w), .oGameOver(over_w), .oWin(win_w), .oState(st_w));
  typedef struct {
    logic rst_n; logic [3:0] btn; logic eat; logic col; logic ack;
    int st; int req; int len; int dir;
  } vec_t;
  vec_t tbl[6];
  int m_st, m_len, m_dir, m_pend, m_cnt, m_tick, m_win;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick && cnt < 200);
  endtask
  function automatic int period(input int l);
`ifdef SNAKE_SPEEDUP_EN
    int p = TB - TS * (l - 3);
    return p < TM ? TM : p;
`else
    return TB;
`endif
  endfunction
  // cycle model: a move happens every period(len) cycles spent in RUN
  task automatic model_step();
    int rq, old_dir, old_pend, nl;
    if (!rst_n) begin
      m_st = 0; m_len = 3; m_dir = 2; m_pend = 2; m_cnt = 0; m_tick = 0; m_win = 0;
      return;
    end
    m_tick = 0;
    rq = btn_n ? 0 : btn_s ? 1 : btn_e ? 2 : btn_w ? 3 : -1;
    old_dir = m_dir;
    old_pend = m_pend;
    case (m_st)
      0: begin m_cnt = 0; if (rq >= 0) m_st = 1; end
      1: if (ack) m_st = 2;
      2: begin
        if (col) m_st = 3;
        else if (eat) begin
          nl = m_len + 1 > MAXL ? MAXL : m_len + 1;
          m_len = nl;
          if (nl == MAXL) begin m_st = 3; m_win = 1; end
          else m_st = 1;
        end else if (m_cnt + 1 >= period(m_len)) begin
          m_tick = 1; m_cnt = 0; m_dir = old_pend;
        end else m_cnt++;
        if (rq >= 0 && !(rq / 2 == old_dir / 2 && rq != old_dir)) m_pend = rq;
      end
      default: m_cnt = 0;
    endcase
  endtask
  initial begin
    int n, ticks;
    tbl[0] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 3, 2};
    tbl[1] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 0, 3, 2};
    tbl[2] = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1, 3, 2};
    tbl[3] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1, 1, 3, 2};
    tbl[4] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1, 3, 2};
    tbl[5] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2, 0, 3, 2};
    #2;
    for (int i = 0; i < 6; i++) begin
      rst_n = tbl[i].rst_n;
      {btn_n, btn_s, btn_e, btn_w} = tbl[i].btn;
      eat = tbl[i].eat; col = tbl[i].col; ack = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_state", i), st, tbl[i].st);
      chk($sformatf("tbl%0d_foodreq", i), req, tbl[i].req);
      chk($sformatf("tbl%0d_len", i), len, tbl[i].len);
      chk($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
      chk($sformatf("tbl%0d_tick", i), tick, 0);
      chk($sformatf("tbl%0d_over", i), over, 0);
      chk($sformatf("tbl%0d_win", i), win, 0);
    end
    {btn_n, btn_s, btn_e, btn_w, eat, col, ack} = '0;
    wait_tick(n); chk("first_tick_delay", n, 20);
    step(); chk("tick_one_cycle", tick, 0);
    wait_tick(n); chk("second_tick_period", n, 19);
    btn_w = 1;
    wait_tick(n); chk("reverse_tick_period", n, 20);
    chk("reverse_ignored_dir", dir, 2);
    btn_w = 0; btn_n = 1;
    step();
    btn_n = 0;
    chk("north_not_yet", dir, 2);
    repeat (18) step();
    chk("pre_commit_dir", dir, 2);
    chk("pre_commit_tick", tick, 0);
    step();
    chk("commit_tick", tick, 1);
    chk("commit_dir", dir, 0);
    for (int i = 1; i <= 7; i++) begin
      eat = 1; step(); eat = 0;
      chk($sformatf("eat%0d_len", i), len, 3 + i);
      chk($sformatf("eat%0d_state", i), st, 1);
      chk($sformatf("eat%0d_foodreq", i), req, 1);
      if (i == 2) begin
        chk("win_len", len_w, 5);
        chk("win_state", st_w, 3);
        chk("win_flag", win_w, 1);
        chk("win_over", over_w, 1);
      end
      ack = 1; step(); ack = 0;
      chk($sformatf("ack%0d_state", i), st, 2);
      if (i >= 2) chk($sformatf("win_foodreq%0d", i), req_w, 0);
      if (i == 3) begin
        wait_tick(n);
        wait_tick(n); chk("period_len6", n, period(6));
      end
    end
    wait_tick(n);
    wait_tick(n); chk("period_len10", n, period(10));
    chk("win_stays_over", st_w, 3);
    eat = 1; col = 1; step(); eat = 0; col = 0;
    chk("coll_state", st, 3);
    chk("coll_over", over, 1);
    chk("coll_win", win, 0);
    chk("coll_len", len, 10);
    chk("coll_foodreq", req, 0);
    ticks = 0;
    ack = 1; btn_e = 1; eat = 1;
    repeat (60) begin step(); ticks += tick; end
    ack = 0; btn_e = 0; eat = 0;
    chk("over_no_ticks", ticks, 0);
    chk("over_sticky", st, 3);
    chk("over_len_frozen", len, 10);
    rst_n = 0; step(); rst_n = 1;
    chk("over_reset_state", st, 0);
    chk("over_reset_dir", dir, 2);
    chk("over_reset_len", len, 3);
    chk("over_reset_go", over, 0);
    chk("over_reset_win_w", win_w, 0);
    btn_s = 1; step(); btn_s = 0;
    chk("hs_req", req, 1);
    step(); chk("hs_req_hold", req, 1);
    rst_n = 0; ack = 1; step(); rst_n = 1; ack = 0;
    chk("hs_reset_state", st, 0);
    chk("hs_reset_req", req, 0);
    chk("hs_reset_len", len, 3);
    chk("hs_reset_dir", dir, 2);
    rst_n = 0; step(); model_step();
    for (int c = 0; c < 4000; c++) begin
      rst_n = $urandom_range(0, 299) != 0;
      btn_n = $urandom_range(0, 5) == 0;
      btn_s = $urandom_range(0, 5) == 0;
      btn_e = $urandom_range(0, 5) == 0;
      btn_w = $urandom_range(0, 5) == 0;
      eat = $urandom_range(0, 24) == 0;
      col = $urandom_range(0, 399) == 0;
      ack = $urandom_range(0, 3) == 0;
      step();
      model_step();
      chk($sformatf("rand%0d st/req/len/dir/tick/over/win", c),
          int'({st, req, len, dir, tick, over, win}),
          int'({2'(m_st), m_st == 1, 8'(m_len), 2'(m_dir), m_tick == 1, m_st == 3, m_win == 1}));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
